// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial unsigned subtractor, diff = a - b - bin.
// DIGIT bits are processed per clock with the ripple borrow held in a register
// between digits, so one operation takes STEPS = WIDTH/DIGIT cycles.
// WIDTH must be an exact multiple of DIGIT.
// Optional feature macro: SERIAL_SUB_SAT_EN. When defined, an underflowing
// result saturates to 0. The default build wraps modulo 2^WIDTH.
module serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic             accept, last;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             borrow_r;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   step;
  logic [WIDTH-1:0] res_nxt, final_diff;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every clocked register uses <= so all of them update from
    // pre-edge values; blocking assignments here would create ordering races.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: accept start only in IDLE, leave RUN on the last digit.
  always_comb begin
    // NOTE: defaults first, so no path leaves an output unassigned and no
    // latch is inferred.
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One digit of subtraction plus the result-register shift.
  always_comb begin
    step    = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]} - (DIGIT+1)'(borrow_r);
    // New digit enters at the MSB end; after STEPS shifts the register holds
    // exactly this operation's digits, least significant at the bottom.
    res_nxt = (res_sh >> DIGIT) | (WIDTH'(step[DIGIT-1:0]) << (WIDTH - DIGIT));
`ifdef SERIAL_SUB_SAT_EN
    final_diff = step[DIGIT] ? '0 : res_nxt;
`else
    final_diff = res_nxt;
`endif
  end

  // Operand shifting, borrow ripple, step counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shift registers are reset as well, so an aborted operation
      // leaves no stale digits and the idle datapath is deterministic.
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      borrow_r <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      zero     <= 1'b1;
    end else begin
      done <= last;
      if (accept) begin
        a_sh     <= a;
        b_sh     <= b;
        borrow_r <= bin;
        cnt      <= '0;
      end else if (state == RUN) begin
        a_sh     <= a_sh >> DIGIT;
        b_sh     <= b_sh >> DIGIT;
        res_sh   <= res_nxt;
        borrow_r <= step[DIGIT];
        cnt      <= last ? '0 : cnt + CW'(1);
      end
      if (last) begin
        diff   <= final_diff;
        borrow <= step[DIGIT];
        zero   <= (final_diff == '0);
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor. Three instances (DIGIT = 4, 1, 16
// at WIDTH = 16) share inputs; directed handshake/reset cases target the
// DIGIT=4 instance, and a random sweep checks all three against an integer
// reference of a - b - bin.
module tb_serial_subtractor;

  typedef struct {
    logic [15:0] diff;
    logic        borrow;
    logic        zero;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        bin = 1'b0;

  logic        busy4, done4, borrow4, zero4;
  logic [15:0] diff4;
  logic        busy1, done1, borrow1, zero1;
  logic [15:0] diff1;
  logic        busy16, done16, borrow16, zero16;
  logic [15:0] diff16;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4), .zero(zero4));

  serial_subtractor #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1), .zero(zero1));

  serial_subtractor #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy16), .done(done16), .diff(diff16), .borrow(borrow16), .zero(zero16));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed integer arithmetic on the operands.
  function automatic res_t ref_sub(input logic [15:0] av, input logic [15:0] bv, input logic bi);
    int   full;
    res_t r;
    full     = int'(av) - int'(bv) - int'(bi);
    r.borrow = (full < 0);
    r.diff   = 16'(full);
`ifdef SERIAL_SUB_SAT_EN
    if (r.borrow) r.diff = 16'h0000;
`endif
    r.zero   = (r.diff == 16'h0000);
    return r;
  endfunction

  // Called 1 time unit after a rising edge; present operands, let the next
  // edge accept them, then scramble the inputs to prove they are not re-read.
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic bi);
    start = 1'b1;
    a     = av;
    b     = bv;
    bin   = bi;
    @(posedge clk); #1;
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
    bin   = 1'($urandom);
  endtask

  // Count edges until done4 is seen, bounded; busy must stay high meanwhile.
  task automatic wait_done4(output int lat);
    lat = 0;
    while (!done4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (!done4) check("busy_during_run", busy4, 1'b1);
    end
  endtask

  task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv, input logic bi);
    res_t e;
    int   lat;
    e = ref_sub(av, bv, bi);
    start_op(av, bv, bi);
    check({tag, ".busy_after_start"}, busy4, 1'b1);
    check({tag, ".done_low_after_start"}, done4, 1'b0);
    wait_done4(lat);
    check({tag, ".latency"}, lat, 4);
    check({tag, ".busy_at_done"}, busy4, 1'b0);
    check({tag, ".diff"}, diff4, e.diff);
    check({tag, ".borrow"}, borrow4, e.borrow);
    check({tag, ".zero"}, zero4, e.zero);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    res_t e;
    logic s1, s4, s16;

    // Reset values while rst_n is low.
    #12;
    check("reset.busy", busy4, 1'b0);
    check("reset.done", done4, 1'b0);
    check("reset.diff", diff4, 16'h0000);
    check("reset.borrow", borrow4, 1'b0);
    check("reset.zero", zero4, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_op("basic", 16'h1234, 16'h0234, 1'b0);
    do_op("underflow", 16'h0000, 16'h0001, 1'b0);
    do_op("eq_bin1", 16'h5555, 16'h5555, 1'b1);
    do_op("eq_bin0", 16'h5555, 16'h5555, 1'b0);

    // Start pulse mid-run with other operands must be ignored.
    start_op(16'h1234, 16'h0234, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; a = 16'hAAAA; b = 16'h1111; bin = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done4(lat);
    check("midrun.latency", lat, 2);
    check("midrun.diff", diff4, 16'h1000);
    check("midrun.borrow", borrow4, 1'b0);
    // Start presented during the done cycle is accepted immediately.
    do_op("in_done_cycle", 16'h2000, 16'h1000, 1'b0);
    @(posedge clk); #1;
    check("midrun.not_queued_busy", busy4, 1'b0);
    check("midrun.not_queued_done", done4, 1'b0);

    // Reset two cycles into a run: everything back to reset values, no done.
    start_op(16'h0F0F, 16'h0101, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid.busy", busy4, 1'b0);
    check("rst_mid.done", done4, 1'b0);
    check("rst_mid.diff", diff4, 16'h0000);
    check("rst_mid.borrow", borrow4, 1'b0);
    check("rst_mid.zero", zero4, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("rst_mid.no_done", done4, 1'b0);
    end
    do_op("after_reset", 16'hFFFF, 16'h0001, 1'b0);

    // Let the slow DIGIT=1 instance drain before the sweep.
    repeat (20) @(posedge clk);
    #1;

    // Random sweep on all three instances in parallel.
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] av, bv;
      logic        bi;
      av = 16'($urandom);
      bv = 16'($urandom);
      bi = 1'($urandom);
      case (i % 8)
        0: bv = av;
        1: begin av = 16'h0000; bv = 16'hFFFF; end
        2: begin av = 16'hFFFF; bv = 16'h0000; end
        default: ;
      endcase
      e = ref_sub(av, bv, bi);
      start_op(av, bv, bi);
      check("sweep.busy1", busy1, 1'b1);
      check("sweep.busy4", busy4, 1'b1);
      check("sweep.busy16", busy16, 1'b1);
      s1 = 1'b0; s4 = 1'b0; s16 = 1'b0;
      for (int c = 1; c <= 20 && !(s1 && s4 && s16); c++) begin
        @(posedge clk); #1;
        if (!s1 && done1) begin
          s1 = 1'b1;
          check("sweep.d1.latency", c, 16);
          check("sweep.d1.diff", diff1, e.diff);
          check("sweep.d1.borrow", borrow1, e.borrow);
          check("sweep.d1.zero", zero1, e.zero);
        end
        if (!s4 && done4) begin
          s4 = 1'b1;
          check("sweep.d4.latency", c, 4);
          check("sweep.d4.diff", diff4, e.diff);
          check("sweep.d4.borrow", borrow4, e.borrow);
          check("sweep.d4.zero", zero4, e.zero);
        end
        if (!s16 && done16) begin
          s16 = 1'b1;
          check("sweep.d16.latency", c, 1);
          check("sweep.d16.diff", diff16, e.diff);
          check("sweep.d16.borrow", borrow16, e.borrow);
          check("sweep.d16.zero", zero16, e.zero);
        end
      end
      check("sweep.d1.done_seen", s1, 1'b1);
      check("sweep.d4.done_seen", s4, 1'b1);
      check("sweep.d16.done_seen", s16, 1'b1);
      if (!(s1 && s4 && s16)) break;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
